// File: rtl/dsp_pkg.sv
// dsp_pkg: constants and types shared by the DSP slice and its consumers.
//   DWIDTH   - slice operand width; each lane result is 2*DWIDTH bits
//   LATENCY  - default slice pipeline latency (input sample to result)
//   dsp_result_t - packed {resb, resa} pair as presented by the slice
package dsp_pkg;

   localparam int DWIDTH  = 8;
   localparam int LATENCY = 3;

   typedef struct packed {
      logic [2*DWIDTH-1:0] resb;
      logic [2*DWIDTH-1:0] resa;
   } dsp_result_t;

endpackage

// File: rtl/dsp_drain_fifo.sv
// dsp_drain_fifo: synchronous FIFO holding captured slice results.
// Ports:
//   clk, clr_n         - clock, asynchronous active-low reset
//   push, push_data    - write one entry (ignored when full and not popping)
//   pop                - remove the head entry (ignored when empty)
//   head_data          - head entry, stable until popped; 0 after reset
//   count              - number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module dsp_drain_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     clr_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop    = pop && (count != '0);
   // A push into a full FIFO is only legal when the head leaves on the same edge.
   assign do_push   = push && ((count != (AW+1)'(DEPTH)) || do_pop);
   assign head_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dsp_result_drain.sv
// dsp_result_drain: tracks operations issued into a fixed-latency DSP slice,
// captures {resultb, resulta} on the cycle the slice presents each result and
// queues it for a valid/ready consumer. Issue credit keeps the non-stallable
// slice from ever producing a result with nowhere to go.
// Ports:
//   clk, clr_n               - clock, asynchronous active-low reset
//   issue_valid, issue_tag   - operation presented to the slice this cycle
//   issue_ready              - credit available (registers only, no input path)
//   slice_clr                - synchronous slice flush; drops in-flight ops
//   resulta, resultb         - slice lane results
//   out_valid, out_ready     - output handshake
//   out_data, out_tag        - head entry {resultb, resulta} and its tag
//   issue_err                - sticky: issue attempted without credit
// Build option: define DSP_DRAIN_TAG_EN to carry issue_tag through to out_tag;
// otherwise no tag storage exists and out_tag is 0.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. out_valid never depends on out_ready, and out_data/out_tag hold steady
// while out_valid is high and out_ready is low. The issue side is credit based:
// the driver must only assert issue_valid while issue_ready is high.
module dsp_result_drain #(
   parameter int DWIDTH  = dsp_pkg::DWIDTH,
   parameter int LATENCY = dsp_pkg::LATENCY,
   parameter int DEPTH   = 4,
   parameter int TAGW    = 4
) (
   input  logic                  clk,
   input  logic                  clr_n,
   input  logic                  issue_valid,
   input  logic [TAGW-1:0]       issue_tag,
   output logic                  issue_ready,
   input  logic                  slice_clr,
   input  logic [2*DWIDTH-1:0]   resulta,
   input  logic [2*DWIDTH-1:0]   resultb,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DWIDTH-1:0]   out_data,
   output logic [TAGW-1:0]       out_tag,
   output logic                  issue_err
);

   localparam int RW = 4*DWIDTH;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [LATENCY-1:0] trk_v;
   logic [CW-1:0]      fifo_count;
   logic               accept;
   logic               push;

   // Every in-flight op and every stored entry holds one credit, so a result
   // reaching the last stage always finds a free FIFO slot.
   assign issue_ready = (int'(fifo_count) + $countones(trk_v)) < DEPTH;
   assign accept      = issue_valid && issue_ready && !slice_clr;
   assign push        = trk_v[LATENCY-1];
   assign out_valid   = (fifo_count != '0);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         trk_v <= '0;
      end else if (slice_clr) begin
         trk_v <= '0;
      end else begin
         for (int i = LATENCY-1; i > 0; i--) trk_v[i] <= trk_v[i-1];
         trk_v[0] <= accept;
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n)                          issue_err <= 1'b0;
      else if (issue_valid && !issue_ready) issue_err <= 1'b1;
   end

`ifdef DSP_DRAIN_TAG_EN
   logic [TAGW-1:0]    trk_tag [LATENCY];
   logic [RW+TAGW-1:0] head;

   // Tags shift unconditionally; only the valid bits decide what is captured.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         for (int i = 0; i < LATENCY; i++) trk_tag[i] <= '0;
      end else begin
         for (int i = LATENCY-1; i > 0; i--) trk_tag[i] <= trk_tag[i-1];
         trk_tag[0] <= issue_tag;
      end
   end

   dsp_drain_fifo #(.WIDTH(RW+TAGW), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .clr_n     (clr_n),
      .push      (push),
      .push_data ({trk_tag[LATENCY-1], resultb, resulta}),
      .pop       (out_ready),
      .head_data (head),
      .count     (fifo_count)
   );

   assign out_data = head[RW-1:0];
   assign out_tag  = head[RW+:TAGW];
`else
   logic unused_tag;

   assign unused_tag = ^issue_tag;

   dsp_drain_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .clr_n     (clr_n),
      .push      (push),
      .push_data ({resultb, resulta}),
      .pop       (out_ready),
      .head_data (out_data),
      .count     (fifo_count)
   );

   assign out_tag = '0;
`endif

endmodule

// File: tb/tb_dsp_result_drain.sv
// tb_dsp_result_drain: randomized and directed checks of dsp_result_drain
// against a queue-based reference model of issue credit, slice latency,
// flush and FIFO ordering.
module tb_dsp_result_drain;
   import dsp_pkg::*;

   localparam int DW  = 8;
   localparam int LAT = 3;
   localparam int DEP = 4;
   localparam int TW  = 4;
   localparam int RW  = 4*DW;

   // clock / reset
   logic clk = 1'b0;
   logic clr_n = 1'b0;
   always #5 clk = ~clk;

   logic            issue_valid = 1'b0;
   logic [TW-1:0]   issue_tag   = '0;
   logic            slice_clr   = 1'b0;
   logic            out_ready   = 1'b0;
   logic [2*DW-1:0] resulta     = '0;
   logic [2*DW-1:0] resultb     = '0;
   logic            issue_ready;
   logic            out_valid;
   logic [RW-1:0]   out_data;
   logic [TW-1:0]   out_tag;
   logic            issue_err;

   dsp_result_drain #(.DWIDTH(DW), .LATENCY(LAT), .DEPTH(DEP), .TAGW(TW)) dut (
      .clk         (clk),
      .clr_n       (clr_n),
      .issue_valid (issue_valid),
      .issue_tag   (issue_tag),
      .issue_ready (issue_ready),
      .slice_clr   (slice_clr),
      .resulta     (resulta),
      .resultb     (resultb),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_tag     (out_tag),
      .issue_err   (issue_err)
   );

   // scoreboard / reference model
   typedef struct {
      int          due;
      logic [TW-1:0] tag;
   } pend_t;

   pend_t         pend_q[$];
   logic [RW-1:0] exp_q[$];
   logic [TW-1:0] exp_tag_q[$];
   logic          exp_err = 1'b0;
   int            cyc = 0;
   int            total = 0;
   int            bad = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [TW-1:0] tag_of(input logic [TW-1:0] t);
`ifdef DSP_DRAIN_TAG_EN
      return t;
`else
      return (t & '0);
`endif
   endfunction

   function automatic logic model_ready();
      return (exp_q.size() + pend_q.size()) < DEP;
   endfunction

   task automatic check_outputs();
      check("issue_ready", issue_ready, model_ready());
      check("out_valid", out_valid, exp_q.size() != 0);
      check("issue_err", issue_err, exp_err);
      if (exp_q.size() != 0) begin
         check("out_data", out_data, exp_q[0]);
         check("out_tag", out_tag, exp_tag_q[0]);
      end
   endtask

   // driver: present one cycle of inputs, advance the model, check after the edge
   task automatic cycle(input logic iv, input logic [TW-1:0] itag, input logic ordy,
                        input logic sclr, input logic [2*DW-1:0] ra, input logic [2*DW-1:0] rb);
      logic        rdy;
      dsp_result_t r;
      issue_valid = iv;
      issue_tag   = itag;
      out_ready   = ordy;
      slice_clr   = sclr;
      resulta     = ra;
      resultb     = rb;
      rdy = model_ready();
      if (exp_q.size() != 0 && ordy) begin
         void'(exp_q.pop_front());
         void'(exp_tag_q.pop_front());
      end
      if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
         r.resa = ra;
         r.resb = rb;
         exp_q.push_back(r);
         exp_tag_q.push_back(tag_of(pend_q[0].tag));
         void'(pend_q.pop_front());
      end
      if (sclr) pend_q.delete();
      if (iv && !rdy) exp_err = 1'b1;
      if (iv && rdy && !sclr) pend_q.push_back('{cyc + LAT, itag});
      cyc++;
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input logic ordy);
      cycle(1'b0, '0, ordy, 1'b0, 16'($urandom), 16'($urandom));
   endtask

   initial begin
      // reset state
      clr_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_issue_ready", issue_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, '0);
      check("rst_out_tag", out_tag, '0);
      check("rst_issue_err", issue_err, 1'b0);
      clr_n = 1'b1;

      // single result: visible LAT+1 cycles after issue
      repeat (2) idle(1'b0);
      cycle(1'b1, 4'd3, 1'b0, 1'b0, 16'h0012, 16'h0034);
      repeat (LAT-1) cycle(1'b0, '0, 1'b0, 1'b0, 16'h0012, 16'h0034);
      check("t1_not_early", out_valid, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0, 16'h0012, 16'h0034);
      check("t1_valid", out_valid, 1'b1);
      check("t1_data", out_data, 32'h0034_0012);
      check("t1_tag", out_tag, tag_of(4'd3));
      idle(1'b1);

      // fill without draining
      for (int i = 0; i < DEP; i++) cycle(1'b1, 4'(i + 5), 1'b0, 1'b0, 16'($urandom), 16'($urandom));
      check("t2_full_credit", issue_ready, 1'b0);
      repeat (LAT + 1) idle(1'b0);
      check("t2_still_blocked", issue_ready, 1'b0);

      // credit return after a single pop
      idle(1'b1);
      check("t3_credit_back", issue_ready, 1'b1);
      cycle(1'b1, 4'd9, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
      check("t3_credit_used", issue_ready, 1'b0);
      repeat (LAT + 1) idle(1'b0);

      // issue without credit: sticky error, nothing pushed
      cycle(1'b1, 4'd7, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
      check("t5_err_set", issue_err, 1'b1);
      repeat (LAT + 1) idle(1'b0);
      repeat (DEP + 2) idle(1'b1);
      check("t5_err_sticky", issue_err, 1'b1);
      check("t5_drained", out_valid, 1'b0);

      // flush: two in-flight ops dropped, stored entry kept
      cycle(1'b1, 4'd1, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
      repeat (LAT + 1) idle(1'b0);
      cycle(1'b1, 4'd2, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
      cycle(1'b1, 4'd4, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
      cycle(1'b0, '0, 1'b0, 1'b1, 16'($urandom), 16'($urandom));
      check("t4_credit_back", issue_ready, 1'b1);
      repeat (LAT + 2) idle(1'b0);
      check("t4_one_entry", out_valid, 1'b1);
      idle(1'b1);
      check("t4_no_extra", out_valid, 1'b0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic iv;
         iv = ($urandom_range(0, 3) != 0) && (model_ready() || ($urandom_range(0, 19) == 0));
         cycle(iv, 4'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0),
               16'($urandom), 16'($urandom));
      end

      // async reset with entries queued
      repeat (DEP + LAT + 2) idle(1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 4'(i + 10), 1'b0, 1'b0, 16'($urandom), 16'($urandom));
      repeat (LAT + 1) idle(1'b0);
      check("t6_queued", out_valid, 1'b1);
      #2;
      clr_n = 1'b0;
      #1;
      check("t6_out_valid", out_valid, 1'b0);
      check("t6_issue_ready", issue_ready, 1'b1);
      check("t6_issue_err", issue_err, 1'b0);
      check("t6_out_data", out_data, '0);
      pend_q.delete();
      exp_q.delete();
      exp_tag_q.delete();
      exp_err = 1'b0;
      @(negedge clk);
      clr_n = 1'b1;
      cycle(1'b1, 4'd6, 1'b1, 1'b0, 16'($urandom), 16'($urandom));
      repeat (LAT + 2) idle(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dsp_result_drain.md
# dsp_result_drain

Consumer-side companion to the DSP slice: tracks every operation issued into the slice through its fixed pipeline latency, captures `{resultb, resulta}` on the exact cycle the slice output register presents it, and buffers the captured results in a small FIFO drained by a valid/ready handshake. It sits between a slice (or the last slice of a chain) and the downstream datapath. It also provides issue-side credit, so that the slice, which cannot stall, never produces a result with no buffer space for it.

## Interface
Parameters:
- `DWIDTH`, 8: slice operand width; results are 2*DWIDTH per lane.
- `LATENCY`, 3: cycles from slice input sampling to the result on `resulta`/`resultb`; must be ≥1.
- `DEPTH`, 4: FIFO entries; must be a power of two, ≥2.
- `TAGW`, 4: width of the per-operation tag.

Ports:
- `clk` in 1: single clock.
- `clr_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `issue_valid` in 1: an operation is presented to the slice inputs this cycle.
- `issue_tag` in TAGW: tag travelling with the operation.
- `issue_ready` out 1: credit available; the driver presents slice inputs only when this is high.
- `slice_clr` in 1: the same synchronous clear that drives the slice `clr`.
- `resulta` in 2*DWIDTH: slice lane A result.
- `resultb` in 2*DWIDTH: slice lane B result.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: downstream accepts the head.
- `out_data` out 4*DWIDTH: `{resultb, resulta}` of the head entry.
- `out_tag` out TAGW: tag of the head entry.
- `issue_err` out 1: sticky; set when `issue_valid` is asserted while `issue_ready` is low.

## Operation
- **In-flight tracker.** An in-flight tracker holds LATENCY valid bits plus a tag per stage and shifts every cycle.
  - An issue is accepted when `issue_valid && issue_ready`. The accepted issue loads stage 0 with valid=1 and `issue_tag`.
  - Otherwise stage 0 loads valid=0.
- **Capture.** When the last stage's valid bit is 1, the FIFO pushes `{resultb, resulta}` and the last stage's tag at that clock edge.
- **Credit.** `issue_ready = (fifo_count + popcount(tracker valid bits)) < DEPTH`. It is computed combinationally from registers only, so it has no input-to-output path.
- **Overflow.** Obeying `issue_ready` guarantees a push is never dropped.
  - `issue_valid` while `issue_ready` is low does not load the tracker and sets `issue_err`.
  - `issue_err` is cleared only by `clr_n`.
- **Pop.** A pop occurs on `out_valid && out_ready`. `out_valid = (fifo_count != 0)`. `out_data` and `out_tag` come from the head entry and are stable while `out_valid && !out_ready`.
- **Simultaneous push and pop** in the same cycle: the count is unchanged and both pointers advance. A push into an empty FIFO is not bypassed to the output.
- **`slice_clr`.**
  - On the edge where it is sampled high, all tracker valid bits clear, so in-flight operations are discarded, matching the slice flushing its pipeline.
  - An issue in that same cycle is also discarded.
  - FIFO contents, pointers and `issue_err` are kept.
- **Pointer wrap.** Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.

## Timing
- **Reset values:** `issue_ready`=1, `out_valid`=0, `out_data`=0, `out_tag`=0, `issue_err`=0; tracker, pointers and count are 0. `clr_n` deassertion is synchronised by the user.
- **Issue to capture:** an issue accepted at cycle n is pushed at the edge ending cycle n+LATENCY.
- **Issue to output:** `out_valid` rises in cycle n+LATENCY+1 if the FIFO was empty.
- **Credit return:** a pop in cycle m raises `issue_ready` in cycle m+1 if credit was the limit.
- **Back-to-back:** one issue per cycle is sustainable while `out_ready` is held high.
- **Reset mid-operation:** `clr_n` low immediately forces all state to its reset value, whatever is in flight.

## Configuration
- **`DSP_DRAIN_TAG_EN` defined:**
  - Tags are stored per tracker stage and per FIFO entry.
  - `out_tag` carries the tag issued with the result.
- **`DSP_DRAIN_TAG_EN` undefined:**
  - No tag storage is built.
  - `out_tag` is tied to 0 and `issue_tag` is ignored.
  - All other behaviour is identical.

## Structure
- **Shared package `dsp_pkg`:**
  - `DWIDTH` and the default slice `LATENCY` constant.
  - A result typedef: a packed struct with `resb` and `resa` fields, each 2*DWIDTH.
- **Sub-module `dsp_drain_fifo`:** the synchronous FIFO with count output, push/pop ports and async active-low reset, instantiated once.
- The tracker and credit logic stay in the top module.

## Test plan
1. **Single result:** reset, then issue one op at cycle 5 with tag 3 while the slice model outputs resulta=0x0012 and resultb=0x0034 at cycle 8. Required: `out_valid` in cycle 9, `out_data`=0x00340012, `out_tag`=3.
2. **Fill without draining:** with `out_ready`=0, issue every cycle. Required: exactly 4 issues accepted, `issue_ready` low from the cycle after the 4th issue, 4 entries retained in order.
3. **Credit return:** from full, pulse `out_ready` for one cycle. Required: the head pops, `issue_ready` is 1 in the next cycle, one more issue is accepted.
4. **Flush:** issue 2 ops, then assert `slice_clr` one cycle later. Required: neither result is pushed, FIFO contents are unchanged, `issue_ready` returns to 1.
5. **Error flag:** with `issue_ready`=0, assert `issue_valid`. Required: `issue_err`=1 and stays 1 through later traffic; no extra push occurs.
6. **Async reset:** pull `clr_n` low mid-stream with 3 entries queued. Required: `out_valid`=0 and `issue_ready`=1 immediately, without waiting for a clock edge.
